// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot five-phase instruction cycle controller
// (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK) with handshake stalls,
// stall timeout into a sticky ERROR state, and halt at instruction boundaries.
// Optional feature macro: RETIRE_COUNTER_EN adds the instret retire counter.
// Reset rst_n is asynchronous and active-high.

module phase_sequencer #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt_req,
    input  logic            imem_ready,
    input  logic            mem_access,
    input  logic            dmem_ready,
    output logic            phase_fetch,
    output logic            phase_decode,
    output logic            phase_execute,
    output logic            phase_memory,
    output logic            phase_writeback,
    output logic            busy,
    output logic            timeout_err
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [XLEN-1:0] instret
`endif
);

    // Reject parameter values the 8-bit stall counter cannot honour.
    if (XLEN < 1 || MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_params
        $error("phase_sequencer: XLEN must be >= 1 and MEM_TIMEOUT in 2..255");
    end

    // One-hot state encoding: each phase output is a bit of the state register.
    localparam int unsigned S_IDLE_BIT      = 0;
    localparam int unsigned S_FETCH_BIT     = 1;
    localparam int unsigned S_DECODE_BIT    = 2;
    localparam int unsigned S_EXECUTE_BIT   = 3;
    localparam int unsigned S_MEMORY_BIT    = 4;
    localparam int unsigned S_WRITEBACK_BIT = 5;
    localparam int unsigned S_ERROR_BIT     = 6;

    typedef enum logic [6:0] {
        S_IDLE      = 7'b000_0001,
        S_FETCH     = 7'b000_0010,
        S_DECODE    = 7'b000_0100,
        S_EXECUTE   = 7'b000_1000,
        S_MEMORY    = 7'b001_0000,
        S_WRITEBACK = 7'b010_0000,
        S_ERROR     = 7'b100_0000
    } state_t;

    // Stall count value during the MEM_TIMEOUT-th consecutive stalled cycle.
    localparam logic [7:0] STALL_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] stall_cnt_q;
    logic       stalled;
    logic       timeout_hit;

    // Current cycle is waiting on a handshake in FETCH or MEMORY.
    always_comb begin
        stalled = ((state_q == S_FETCH) && !imem_ready) ||
                  ((state_q == S_MEMORY) && mem_access && !dmem_ready);
        timeout_hit = stalled && (stall_cnt_q == STALL_LAST);
    end

    // State register with asynchronous reset into IDLE.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: handshakes advance, timeouts divert to ERROR.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A ready handshake wins over a coincident timeout.
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (!mem_access || dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_WRITEBACK: begin
                state_d = halt_req ? S_IDLE : S_FETCH;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall counter: clears on any state change, counts stalled cycles.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stall_cnt_q <= '0;
        end else if (state_d != state_q) begin
            stall_cnt_q <= '0;
        end else if (stalled) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end

    // Output decode: phase strobes come straight from state register bits.
    always_comb begin
        phase_fetch     = state_q[S_FETCH_BIT];
        phase_decode    = state_q[S_DECODE_BIT];
        phase_execute   = state_q[S_EXECUTE_BIT];
        phase_memory    = state_q[S_MEMORY_BIT];
        phase_writeback = state_q[S_WRITEBACK_BIT];
        busy            = !(state_q[S_IDLE_BIT] || state_q[S_ERROR_BIT]);
        // ERROR is left only through reset, so the flag is sticky by construction.
        timeout_err     = state_q[S_ERROR_BIT];
    end

`ifdef RETIRE_COUNTER_EN
    // Retire counter: every WRITEBACK cycle is an exit from WRITEBACK.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            instret <= '0;
        end else if (state_q == S_WRITEBACK) begin
            instret <= instret + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: a phase-index reference model is
// compared every cycle, and directed scenarios pin hand-computed values.
// Build with RETIRE_COUNTER_EN defined to also exercise instret.

module tb_phase_sequencer;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned MEM_TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            halt_req = 1'b0;
    logic            imem_ready = 1'b0;
    logic            mem_access = 1'b0;
    logic            dmem_ready = 1'b0;
    logic            phase_fetch;
    logic            phase_decode;
    logic            phase_execute;
    logic            phase_memory;
    logic            phase_writeback;
    logic            busy;
    logic            timeout_err;
    logic [XLEN-1:0] instret;

    int checks   = 0;
    int failures = 0;

    phase_sequencer #(.XLEN(XLEN), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .halt_req        (halt_req),
        .imem_ready      (imem_ready),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .phase_fetch     (phase_fetch),
        .phase_decode    (phase_decode),
        .phase_execute   (phase_execute),
        .phase_memory    (phase_memory),
        .phase_writeback (phase_writeback),
        .busy            (busy),
        .timeout_err     (timeout_err)
`ifdef RETIRE_COUNTER_EN
        ,
        .instret         (instret)
`endif
    );

`ifndef RETIRE_COUNTER_EN
    assign instret = '0;
`endif

    always #5 clk = ~clk;

    wire [4:0] ph = {phase_fetch, phase_decode, phase_execute, phase_memory, phase_writeback};

    localparam logic [4:0] P_F = 5'b10000;
    localparam logic [4:0] P_D = 5'b01000;
    localparam logic [4:0] P_E = 5'b00100;
    localparam logic [4:0] P_M = 5'b00010;
    localparam logic [4:0] P_W = 5'b00001;
    localparam logic [4:0] P_0 = 5'b00000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1..5 = F,D,E,M,W in order, 6 = error.
    int              m_mode  = 0;
    int              m_stall = 0;
    logic [XLEN-1:0] m_ret   = '0;

    always @(posedge clk or posedge rst_n) begin
        int nxt;
        bit stall;
        if (rst_n) begin
            m_mode  <= 0;
            m_stall <= 0;
            m_ret   <= '0;
        end else begin
            nxt   = m_mode;
            stall = 1'b0;
            if (m_mode == 0) begin
                if (start) nxt = 1;
            end else if (m_mode == 1) begin
                if (imem_ready) nxt = 2; else stall = 1'b1;
            end else if (m_mode == 2 || m_mode == 3) begin
                nxt = m_mode + 1;
            end else if (m_mode == 4) begin
                if (!mem_access || dmem_ready) nxt = 5; else stall = 1'b1;
            end else if (m_mode == 5) begin
                nxt = halt_req ? 0 : 1;
                m_ret <= m_ret + 1'b1;
            end
            if (stall && (m_stall + 1 >= int'(MEM_TIMEOUT))) nxt = 6;
            m_stall <= (stall && nxt == m_mode) ? m_stall + 1 : 0;
            m_mode  <= nxt;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [4:0] top;
        logic [4:0] exp_ph;
        top    = P_F;
        exp_ph = (m_mode >= 1 && m_mode <= 5) ? (top >> (m_mode - 1)) : P_0;
        check("model_phases", 64'(ph), 64'(exp_ph));
        check("model_busy", 64'(busy), 64'(m_mode >= 1 && m_mode <= 5));
        check("model_timeout_err", 64'(timeout_err), 64'(m_mode == 6));
`ifdef RETIRE_COUNTER_EN
        check("model_instret", 64'(instret), 64'(m_ret));
`endif
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        start      = 1'b0;
        halt_req   = 1'b0;
        imem_ready = 1'b0;
        mem_access = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("reset_phases", 64'(ph), 64'(P_0));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_timeout_err", 64'(timeout_err), 64'd0);
        check("reset_instret", 64'(instret), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    // Leaves the bench at the negedge of the first FETCH cycle.
    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [4:0] top;
        top = P_F;

        // Back-to-back unstalled instructions.
        do_reset();
        imem_ready = 1'b1;
        start_pulse();
        for (int i = 0; i < 20; i++) begin
            check("run_phase", 64'(ph), 64'(top >> (i % 5)));
            check("run_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
`ifdef RETIRE_COUNTER_EN
        check("run_instret_4", 64'(instret), 64'd4);
`endif

        // Fetch stall of 3 cycles: F held 4 cycles, then D.
        do_reset();
        start_pulse();
        for (int i = 0; i < 4; i++) begin
            check("fstall_fetch", 64'(ph), 64'(P_F));
            check("fstall_busy", 64'(busy), 64'd1);
            if (i == 3) imem_ready = 1'b1;
            @(negedge clk);
        end
        check("fstall_decode", 64'(ph), 64'(P_D));

        // Memory stall of 5 cycles: M held 6 cycles, then W.
        do_reset();
        imem_ready = 1'b1;
        mem_access = 1'b1;
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      check("mstall_ph", 64'(ph), 64'(P_F));
            else if (i == 1) check("mstall_ph", 64'(ph), 64'(P_D));
            else if (i == 2) check("mstall_ph", 64'(ph), 64'(P_E));
            else if (i < 9)  check("mstall_mem", 64'(ph), 64'(P_M));
            else             check("mstall_wb", 64'(ph), 64'(P_W));
            if (i == 8) dmem_ready = 1'b1;
            @(negedge clk);
        end

        // Memory timeout: 16 MEMORY cycles, then sticky ERROR.
        do_reset();
        imem_ready = 1'b1;
        mem_access = 1'b1;
        start_pulse();
        for (int i = 0; i < 19; i++) begin
            if (i >= 3) check("tmo_mem", 64'(ph), 64'(P_M));
            check("tmo_err_low", 64'(timeout_err), 64'd0);
            @(negedge clk);
        end
        check("tmo_phases", 64'(ph), 64'(P_0));
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_err", 64'(timeout_err), 64'd1);
        dmem_ready = 1'b1;
        start_pulse();
        for (int i = 0; i < 3; i++) begin
            check("tmo_ignore_start", 64'(ph), 64'(P_0));
            check("tmo_sticky", 64'(timeout_err), 64'd1);
            @(negedge clk);
        end

        // Halt during the second WRITEBACK; earlier halt_req is ignored.
        do_reset();
        imem_ready = 1'b1;
        start_pulse();
        for (int i = 0; i < 10; i++) begin
            check("halt_run", 64'(ph), 64'(top >> (i % 5)));
            if (i == 5) halt_req = 1'b1;
            @(negedge clk);
        end
        check("halt_idle_ph", 64'(ph), 64'(P_0));
        check("halt_idle_busy", 64'(busy), 64'd0);
`ifdef RETIRE_COUNTER_EN
        check("halt_instret_2", 64'(instret), 64'd2);
`endif
        halt_req = 1'b0;
        start_pulse();
        check("halt_resume", 64'(ph), 64'(P_F));

        // Reset asserted mid-EXECUTE clears outputs at once.
        do_reset();
        imem_ready = 1'b1;
        start_pulse();
        @(negedge clk);
        @(negedge clk);
        check("rstx_in_exec", 64'(ph), 64'(P_E));
        rst_n = 1'b1;
        #1;
        check("rstx_phases", 64'(ph), 64'(P_0));
        check("rstx_busy", 64'(busy), 64'd0);
        check("rstx_instret", 64'(instret), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        start_pulse();
        check("rstx_fetch", 64'(ph), 64'(P_F));
        @(negedge clk);
        check("rstx_decode", 64'(ph), 64'(P_D));

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
